// File: rtl/ps2_pkg.sv
// Purpose: shared types and constants for the PS/2 scan-code receiver.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_state_e;

  localparam logic [7:0] PS2_PFX_EXT    = 8'hE0;
  localparam logic [7:0] PS2_PFX_REL    = 8'hF0;
  localparam int         PS2_FRAME_BITS = 11;
  // Start, parity and stop bits wrap the data byte.
  localparam int         PS2_DATA_BITS  = PS2_FRAME_BITS - 3;

  // A frame is accepted when the stop bit is high and data plus parity has odd weight.
  function automatic logic ps2_frame_ok(input logic [7:0] data, input logic par, input logic stp);
    return stp & (^data ^ par);
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Purpose: 2-flop synchronizer plus FILT_LEN-sample level filter for one PS/2 line.
// Latency: 2 cycles sync + FILT_LEN cycles before line_filt follows a stable new level.
// Backpressure: none; free-running.
// Ports: clk, reset (sync, active-high), line_raw (async in),
//        line_filt (filtered level), fall_pulse (1-cycle, first cycle line_filt is low).
module ps2_line_filter #(
  parameter int FILT_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic line_raw,
  output logic line_filt,
  output logic fall_pulse
);

  localparam int CW = $clog2(FILT_LEN + 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] run_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      line_filt  <= 1'b1;
      run_cnt    <= '0;
      fall_pulse <= 1'b0;
    end else begin
      sync1      <= line_raw;
      sync2      <= sync1;
      fall_pulse <= 1'b0;
      // run_cnt counts consecutive synchronized samples that disagree with
      // the filtered level; any agreeing sample restarts the run.
      if (sync2 != line_filt) begin
        if (run_cnt == CW'(FILT_LEN - 1)) begin
          line_filt  <= sync2;
          run_cnt    <= '0;
          fall_pulse <= line_filt;
        end else begin
          run_cnt <= run_cnt + 1'b1;
        end
      end else begin
        run_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_scancode_rx.sv
// Purpose: PS/2 keyboard frame receiver that folds E0/F0 prefixes into key events.
// Latency: key_strobe / err_strobe one cycle after the stop bit is sampled.
// Backpressure: none; strobes are single-cycle and outputs hold until the next key_strobe.
// Ports: clk, reset (sync, active-high), ps2_clk/ps2_dat (raw async lines),
//        key_strobe/key_code/key_ext/key_release (decoded event), err_strobe (discarded frame).
module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int FILT_LEN    = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       key_strobe,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_release,
  output logic       err_strobe
);

  localparam int WW = $clog2(TIMEOUT_CYC + 1);

  logic          clk_filt;
  logic          clk_fall;
  logic          dat_s1;
  logic          dat_s2;
  logic          bit_take;
  ps2_state_e    state;
  ps2_state_e    state_nxt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [WW-1:0] wdog;
  logic          timeout;
  logic          pend_ext;
  logic          pend_rel;

  ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_clk_filt (
    .clk        (clk),
    .reset      (reset),
    .line_raw   (ps2_clk),
    .line_filt  (clk_filt),
    .fall_pulse (clk_fall)
  );

  // Data line needs only the synchronizer; it is sampled on clock edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      dat_s1 <= ps2_dat;
      dat_s2 <= dat_s1;
    end
  end

  // The fall pulse coincides with the first low cycle of the filtered clock.
  assign bit_take = clk_fall & ~clk_filt;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    timeout   = 1'b0;
    if (state != ST_IDLE && !bit_take && wdog == WW'(TIMEOUT_CYC - 1)) begin
      timeout   = 1'b1;
      state_nxt = ST_IDLE;
    end else if (bit_take) begin
      case (state)
        ST_IDLE:   if (!dat_s2) state_nxt = ST_DATA;
        ST_DATA:   if (bit_cnt == 3'(PS2_DATA_BITS - 1)) state_nxt = ST_PARITY;
        ST_PARITY: state_nxt = ST_STOP;
        ST_STOP:   state_nxt = ST_IDLE;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt     <= '0;
      shreg       <= '0;
      par_bit     <= 1'b0;
      wdog        <= '0;
      pend_ext    <= 1'b0;
      pend_rel    <= 1'b0;
      key_strobe  <= 1'b0;
      err_strobe  <= 1'b0;
      key_code    <= '0;
      key_ext     <= 1'b0;
      key_release <= 1'b0;
    end else begin
      key_strobe <= 1'b0;
      err_strobe <= 1'b0;

      // Watchdog only runs while a frame is open; every clock edge rearms it.
      if (bit_take || state == ST_IDLE || timeout) wdog <= '0;
      else                                        wdog <= wdog + 1'b1;

      if (timeout) begin
        err_strobe <= 1'b1;
        pend_ext   <= 1'b0;
        pend_rel   <= 1'b0;
      end else if (bit_take) begin
        case (state)
          ST_IDLE: begin
            bit_cnt <= '0;
            shreg   <= '0;
          end
          ST_DATA: begin
            shreg   <= {dat_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          ST_PARITY: par_bit <= dat_s2;
          ST_STOP: begin
            if (ps2_frame_ok(shreg, par_bit, dat_s2)) begin
              if (shreg == PS2_PFX_EXT) begin
                pend_ext <= 1'b1;
              end else if (shreg == PS2_PFX_REL) begin
                pend_rel <= 1'b1;
              end else begin
                key_strobe  <= 1'b1;
                key_code    <= shreg;
                key_ext     <= pend_ext;
                key_release <= pend_rel;
                pend_ext    <= 1'b0;
                pend_rel    <= 1'b0;
              end
            end else begin
              err_strobe <= 1'b1;
              pend_ext   <= 1'b0;
              pend_rel   <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Purpose: randomized scoreboard bench for ps2_scancode_rx with directed corner frames.
// Latency: n/a.
// Backpressure: n/a.
module tb_ps2_scancode_rx;

  localparam int HALF = 20;  // ps2_clk half period in clk cycles

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_dat;
  logic       key_strobe;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_release;
  logic       err_strobe;

  ps2_scancode_rx #(.FILT_LEN(4), .TIMEOUT_CYC(2000)) dut (
    .clk         (clk),
    .reset       (reset),
    .ps2_clk     (ps2_clk),
    .ps2_dat     (ps2_dat),
    .key_strobe  (key_strobe),
    .key_code    (key_code),
    .key_ext     (key_ext),
    .key_release (key_release),
    .err_strobe  (err_strobe)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [7:0] code;
    bit         ext;
    bit         rel;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         n_cmp = 0;
  int         n_bad = 0;
  bit         pe = 0, pr = 0;          // reference prefix state
  logic [7:0] h_code = 8'h00;          // reference held outputs
  bit         h_ext = 0, h_rel = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: a whole received byte (or a discarded frame) at a time.
  task automatic model_frame(input logic [7:0] b, input bit good);
    if (!good) begin
      exp_q.push_back('{1'b1, 8'h00, 1'b0, 1'b0});
      pe = 0; pr = 0;
    end else if (b == 8'hE0) begin
      pe = 1;
    end else if (b == 8'hF0) begin
      pr = 1;
    end else begin
      exp_q.push_back('{1'b0, b, pe, pr});
      h_code = b; h_ext = pe; h_rel = pr;
      pe = 0; pr = 0;
    end
  endtask

  task automatic send_bits(input logic [10:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = bits[i];
      wait_cyc(HALF / 2);
      ps2_clk = 1'b0;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
      wait_cyc(HALF / 2);
    end
    ps2_dat = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic par;
    par = ~(^b) ^ bad_par;
    model_frame(b, !bad_par && !bad_stop);
    send_bits({~bad_stop, par, b, 1'b0}, 11);
    wait_cyc(5 + $urandom_range(0, 30));
  endtask

  task automatic check_held(input string nm);
    @(negedge clk);
    chk({nm, "_code"}, 32'(key_code), 32'(h_code));
    chk({nm, "_ext"}, 32'(key_ext), 32'(h_ext));
    chk({nm, "_rel"}, 32'(key_release), 32'(h_rel));
  endtask

  task automatic do_reset(input string nm);
    reset = 1'b1;
    wait_cyc(3);
    exp_q.delete();
    pe = 0; pr = 0; h_code = 8'h00; h_ext = 0; h_rel = 0;
    @(negedge clk);
    chk({nm, "_strobe"}, 32'(key_strobe), 32'd0);
    chk({nm, "_err"}, 32'(err_strobe), 32'd0);
    chk({nm, "_code"}, 32'(key_code), 32'd0);
    chk({nm, "_ext"}, 32'(key_ext), 32'd0);
    chk({nm, "_rel"}, 32'(key_release), 32'd0);
    wait_cyc(1);
    reset = 1'b0;
    wait_cyc(2);
  endtask

  // Monitor: every strobe pops one expected event.
  always @(negedge clk) begin
    if (!reset && (key_strobe || err_strobe)) begin
      if (key_strobe && err_strobe) chk("both_strobes", 32'd1, 32'd0);
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_strobe: key=%0b err=%0b code=%0h, expected no event",
                 key_strobe, err_strobe, key_code);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.is_err ? !(err_strobe && !key_strobe)
                         : !(key_strobe && !err_strobe && key_code == mon_e.code &&
                             key_ext == mon_e.ext && key_release == mon_e.rel)) begin
          n_bad++;
          $display("FAIL event: got key=%0b err=%0b code=%0h ext=%0b rel=%0b, expected err=%0b code=%0h ext=%0b rel=%0b",
                   key_strobe, err_strobe, key_code, key_ext, key_release,
                   mon_e.is_err, mon_e.code, mon_e.ext, mon_e.rel);
        end
      end
    end
  end

  initial begin
    logic [7:0] b;
    int         r;
    bit         bp, bs;
    reset   = 1'b1;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    do_reset("reset");

    send_frame(8'h1C, 0, 0);
    check_held("single_1c");

    send_frame(8'hF0, 0, 0);
    send_frame(8'h1C, 0, 0);
    check_held("release_1c");

    send_frame(8'hE0, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h6B, 0, 0);
    send_frame(8'h6B, 0, 0);
    check_held("ext_rel_6b");

    send_frame(8'h5A, 1, 0);
    check_held("parity_err");

    // Start plus four data bits, then silence past the watchdog.
    exp_q.push_back('{1'b1, 8'h00, 1'b0, 1'b0});
    pe = 0; pr = 0;
    send_bits({1'b1, 1'b0, 8'h29, 1'b0}, 5);
    wait_cyc(2100);
    send_frame(8'h29, 0, 0);
    check_held("after_timeout");

    // Short low glitch with data low must not open a frame.
    ps2_dat = 1'b0;
    ps2_clk = 1'b0;
    wait_cyc(2);
    ps2_clk = 1'b1;
    wait_cyc(10);
    ps2_dat = 1'b1;
    wait_cyc(2100);
    check_held("glitch");

    // Reset during bit 5 with an E0 pending; the prefix must not survive.
    send_frame(8'hE0, 0, 0);
    send_bits({1'b1, 1'b1, 8'h33, 1'b0}, 6);
    do_reset("mid_reset");
    send_frame(8'h1C, 0, 0);
    check_held("post_reset");

    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0: b = 8'hE0;
        1: b = 8'hF0;
        2: b = 8'hE1;
        3: b = 8'hAA;
        4: b = 8'hFA;
        default: b = 8'($urandom);
      endcase
      bp = ($urandom_range(0, 7) == 0);
      bs = !bp && ($urandom_range(0, 9) == 0);
      send_frame(b, bp, bs);
    end
    check_held("random_end");

    wait_cyc(50);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
